// File: rtl/tof_trig_sequencer_pkg.sv
// Package: tof_trig_pkg
//
// Purpose:
//   Shared types and constants for the time-of-flight trigger sequencer
//   slice (sequencer top, its bus interface and the edge synchroniser).
//
// Contents:
//   CW_DEFAULT   default timestamp / timeout width
//   PW_DEFAULT   default pulse-length field width
//   NIN_DEFAULT  number of trigger inputs (the design is built for 2)
//   SYNC_LAT     pin-to-edge-detect latency in cycles; software subtracts
//                this from the returned stamps
//   STAMP_NONE   stamp value reported for a channel that saw no edge
//   state_t      sequencer FSM states

package tof_trig_pkg;

    localparam int CW_DEFAULT  = 16;
    localparam int PW_DEFAULT  = 8;
    localparam int NIN_DEFAULT = 2;

    localparam int SYNC_LAT = 3;

    localparam logic [CW_DEFAULT-1:0] STAMP_NONE = '1;

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        WAIT,
        RSP
    } state_t;

endpackage

// File: rtl/tof_trig_sequencer_if.sv
// Interface: tof_trig_sequencer_if
//
// Purpose:
//   Command / response handshake between the SoC peripheral bus adapter
//   (master) and the trigger sequencer (slave).
//
// Signals:
//   cmd_valid      command present (master -> slave)
//   cmd_ready      command accepted when valid && ready (slave -> master)
//   cmd_pulse_len  pulse width in cycles, 0 treated as 1
//   cmd_timeout    cycles from pulse start to forced completion
//   rsp_valid      result present, held until rsp_ready
//   rsp_ready      result consumed
//   rsp_hit        per-input edge-captured flags
//   rsp_stamp0/1   counter value at each input's first edge, all-ones if none

interface tof_trig_sequencer_if
    import tof_trig_pkg::*;
#(
    parameter int CW  = CW_DEFAULT,
    parameter int PW  = PW_DEFAULT,
    parameter int NIN = NIN_DEFAULT
);

    logic           cmd_valid;
    logic           cmd_ready;
    logic [PW-1:0]  cmd_pulse_len;
    logic [CW-1:0]  cmd_timeout;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [NIN-1:0] rsp_hit;
    logic [CW-1:0]  rsp_stamp0;
    logic [CW-1:0]  rsp_stamp1;

    modport master (
        output cmd_valid, cmd_pulse_len, cmd_timeout, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_hit, rsp_stamp0, rsp_stamp1
    );

    modport slave (
        input  cmd_valid, cmd_pulse_len, cmd_timeout, rsp_ready,
        output cmd_ready, rsp_valid, rsp_hit, rsp_stamp0, rsp_stamp1
    );

endinterface

// File: rtl/tof_trig_edge_sync.sv
// Module: tof_trig_edge_sync
//
// Purpose:
//   Brings one asynchronous trigger pad into the clock domain through a
//   2-FF synchroniser and produces a registered one-cycle pulse on each
//   rising edge of the synchronised level. A pad change first shows up on
//   'rise' three cycles after the cycle in which it was sampled.
//
// Ports:
//   clk   in   system clock, rising edge
//   rst   in   synchronous active-high reset
//   din   in   asynchronous pad level
//   rise  out  one-cycle pulse on a synchronised rising edge

module tof_trig_edge_sync
    import tof_trig_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic meta;
    logic sync;
    logic sync_d;

    // Two flops for metastability, a third holding the previous synchronised
    // level, and the edge pulse itself registered so the capture logic sees a
    // clean flop output. This runs in every sequencer state so that a level
    // already high when a command arrives is not mistaken for an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta   <= 1'b0;
            sync   <= 1'b0;
            sync_d <= 1'b0;
            rise   <= 1'b0;
        end else begin
            meta   <= din;
            sync   <= meta;
            sync_d <= sync;
            rise   <= sync & ~sync_d;
        end
    end

endmodule

// File: rtl/tof_trig_sequencer.sv
// Module: tof_trig_sequencer
//
// Purpose:
//   Runs one time-of-flight shot: on an accepted command it drives a pulse
//   on io_trigsOut for pulse_len cycles, counts cycles from the first pulse
//   cycle, timestamps the first rising edge on each trigger input and
//   returns the result on the response handshake. The shot ends when both
//   inputs have been captured or when the counter reaches the timeout.
//
// Ports:
//   io_mainClk   in   system clock, rising edge
//   io_reset     in   synchronous active-high reset
//   bus          slave side of the command/response interface
//   io_trigsOut  out  registered trigger pulse to the pad
//   io_trigsIn   in   asynchronous trigger inputs from the pads
//   io_busy      out  high whenever the sequencer is not idle

module tof_trig_sequencer
    import tof_trig_pkg::*;
#(
    parameter int CW  = CW_DEFAULT,
    parameter int PW  = PW_DEFAULT,
    parameter int NIN = NIN_DEFAULT
)(
    input  logic                  io_mainClk,
    input  logic                  io_reset,
    tof_trig_sequencer_if.slave   bus,
    output logic                  io_trigsOut,
    input  logic [NIN-1:0]        io_trigsIn,
    output logic                  io_busy
);

    state_t         state;
    logic           cmd_ready_q;
    logic           rsp_valid_q;
    logic           trig_q;
    logic           busy_q;
    logic [PW-1:0]  pulse_left;
    logic [CW-1:0]  timeout_q;
    logic [CW-1:0]  counter;
    logic [NIN-1:0] hit_q;
    logic [CW-1:0]  stamp_q [NIN];

    logic [NIN-1:0] rise;
    logic           capture_en;
    logic [NIN-1:0] new_hit;
    logic           all_hit;
    logic [CW-1:0]  counter_next;

    for (genvar g = 0; g < NIN; g++) begin : g_sync
        tof_trig_edge_sync u_sync (
            .clk  (io_mainClk),
            .rst  (io_reset),
            .din  (io_trigsIn[g]),
            .rise (rise[g])
        );
    end

    // Only the first edge per channel counts, and only while the shot is
    // live. The completion check includes edges landing this very cycle so a
    // second-channel edge ends WAIT without an extra idle cycle.
    always_comb begin
        capture_en   = (state == PULSE) || (state == WAIT);
        new_hit      = rise & ~hit_q & {NIN{capture_en}};
        all_hit      = &(hit_q | new_hit);
        counter_next = (&counter) ? counter : counter + 1'b1;
    end

    // Sequencer FSM with all outputs registered. The timestamp counter starts
    // at 0 in the first PULSE cycle and saturates instead of wrapping, so an
    // all-ones timeout ends the shot exactly at saturation. The timeout is
    // only evaluated in WAIT, which lets a pulse longer than the timeout run
    // to completion.
    always_ff @(posedge io_mainClk) begin
        if (io_reset) begin
            state       <= IDLE;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            trig_q      <= 1'b0;
            busy_q      <= 1'b0;
            pulse_left  <= '0;
            timeout_q   <= '0;
            counter     <= '0;
            hit_q       <= '0;
            for (int i = 0; i < NIN; i++) begin
                stamp_q[i] <= '1;
            end
        end else begin
            for (int i = 0; i < NIN; i++) begin
                if (new_hit[i]) begin
                    hit_q[i]   <= 1'b1;
                    stamp_q[i] <= counter;
                end
            end

            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        state       <= PULSE;
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        trig_q      <= 1'b1;
                        pulse_left  <= (bus.cmd_pulse_len == '0) ? PW'(1) : bus.cmd_pulse_len;
                        timeout_q   <= bus.cmd_timeout;
                        counter     <= '0;
                        hit_q       <= '0;
                        for (int i = 0; i < NIN; i++) begin
                            stamp_q[i] <= '1;
                        end
                    end
                end
                PULSE: begin
                    counter <= counter_next;
                    if (pulse_left == PW'(1)) begin
                        state  <= WAIT;
                        trig_q <= 1'b0;
                    end else begin
                        pulse_left <= pulse_left - 1'b1;
                    end
                end
                WAIT: begin
                    counter <= counter_next;
                    if (all_hit || (counter >= timeout_q)) begin
                        state       <= RSP;
                        rsp_valid_q <= 1'b1;
                    end
                end
                RSP: begin
                    if (bus.rsp_ready) begin
                        state       <= IDLE;
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready  = cmd_ready_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_hit    = hit_q;
    assign bus.rsp_stamp0 = stamp_q[0];
    assign bus.rsp_stamp1 = stamp_q[1];
    assign io_trigsOut    = trig_q;
    assign io_busy        = busy_q;

endmodule

// File: tb/tb_tof_trig_sequencer.sv
// Testbench: tb_tof_trig_sequencer
//
// Purpose:
//   Self-checking bench for tof_trig_sequencer. Each shot's input waveforms
//   are stored per cycle (cycle 0 is the command-acceptance cycle); the
//   reference model derives edge-detect cycles, end of shot, hit flags and
//   stamps from those waveforms with plain arithmetic, and every cycle of
//   the shot is compared against it.

module tb_tof_trig_sequencer;
    import tof_trig_pkg::*;

    localparam int WLEN = 300;

    logic       io_mainClk = 1'b0;
    logic       io_reset   = 1'b1;
    logic [1:0] trigs_in   = 2'b00;
    logic       trigs_out;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    bit wave [2][WLEN];

    tof_trig_sequencer_if bus_if ();

    tof_trig_sequencer dut (
        .io_mainClk  (io_mainClk),
        .io_reset    (io_reset),
        .bus         (bus_if),
        .io_trigsOut (trigs_out),
        .io_trigsIn  (trigs_in),
        .io_busy     (busy)
    );

    // 10-unit clock; all stimulus and sampling happen 1 unit after a rising edge
    always #5 io_mainClk = ~io_mainClk;

    task automatic step();
        @(posedge io_mainClk);
        #1;
    endtask

    // Pad level at a given cycle; before cycle 0 the level is held at wave[..][0]
    function automatic bit in_at(input int ch, input int j);
        if (j < 0) j = 0;
        return wave[ch][j];
    endfunction

    task automatic clear_waves(input bit l0, input bit l1);
        for (int k = 0; k < WLEN; k++) begin
            wave[0][k] = l0;
            wave[1][k] = l1;
        end
    endtask

    task automatic set_level(input int ch, input int from, input int upto, input bit v);
        for (int k = from; k < upto; k++) wave[ch][k] = v;
    endtask

    task automatic gen_wave(input int rate);
        for (int ch = 0; ch < 2; ch++) begin
            bit lvl;
            lvl = 1'($urandom_range(0, 1));
            for (int k = 0; k < WLEN; k++) begin
                if (k > 0 && $urandom_range(0, rate - 1) == 0) lvl = ~lvl;
                wave[ch][k] = lvl;
            end
        end
    endtask

    // One complete shot: model, accept, per-cycle checks, response handshake.
    task automatic run_shot(input int len, input int to, input int rsp_delay,
                            input bit hold_valid, input string name);
        int         l_eff, w_to, w_hit, w_end;
        int         det [2];
        logic [1:0]  exp_hit;
        logic [15:0] exp_s0, exp_s1;

        l_eff = (len == 0) ? 1 : len;
        w_to  = (to + 1 > l_eff + 1) ? to + 1 : l_eff + 1;
        for (int ch = 0; ch < 2; ch++) begin
            det[ch] = -1;
            for (int k = 1; k <= w_to; k++) begin
                if (in_at(ch, k - 3) && !in_at(ch, k - 4)) begin
                    det[ch] = k;
                    break;
                end
            end
        end
        w_hit = w_to;
        if (det[0] > 0 && det[1] > 0) begin
            w_hit = (det[0] > det[1]) ? det[0] : det[1];
            if (w_hit < l_eff + 1) w_hit = l_eff + 1;
        end
        w_end = (w_hit < w_to) ? w_hit : w_to;
        exp_hit[0] = (det[0] > 0) && (det[0] <= w_end);
        exp_hit[1] = (det[1] > 0) && (det[1] <= w_end);
        exp_s0 = exp_hit[0] ? 16'(det[0] - 1) : 16'hFFFF;
        exp_s1 = exp_hit[1] ? 16'(det[1] - 1) : 16'hFFFF;

        bus_if.cmd_valid = 1'b0;
        trigs_in = {wave[1][0], wave[0][0]};
        repeat (6) step();

        bus_if.cmd_pulse_len = 8'(len);
        bus_if.cmd_timeout   = 16'(to);
        bus_if.cmd_valid     = 1'b1;
        checks++;
        if (bus_if.cmd_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL %s idle_ready: ready=%b busy=%b required ready=1 busy=0",
                     name, bus_if.cmd_ready, busy);
        end
        step();
        if (!hold_valid) bus_if.cmd_valid = 1'b0;

        for (int k = 1; k <= w_end + 1; k++) begin
            trigs_in = {wave[1][k], wave[0][k]};
            checks++;
            if (trigs_out !== (k <= l_eff)) begin
                failures++;
                $display("FAIL %s trigs_out cycle %0d: got %b required %b",
                         name, k, trigs_out, (k <= l_eff));
            end
            checks++;
            if (bus_if.rsp_valid !== (k == w_end + 1)) begin
                failures++;
                $display("FAIL %s rsp_valid cycle %0d: got %b required %b",
                         name, k, bus_if.rsp_valid, (k == w_end + 1));
            end
            checks++;
            if (busy !== 1'b1 || bus_if.cmd_ready !== 1'b0) begin
                failures++;
                $display("FAIL %s busy cycle %0d: busy=%b ready=%b required busy=1 ready=0",
                         name, k, busy, bus_if.cmd_ready);
            end
            if (k <= w_end) step();
        end

        for (int d = 0; d <= rsp_delay; d++) begin
            if (d > 0) begin
                step();
                checks++;
                if (bus_if.rsp_valid !== 1'b1 || bus_if.cmd_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL %s rsp_hold %0d: valid=%b ready=%b required valid=1 ready=0",
                             name, d, bus_if.rsp_valid, bus_if.cmd_ready);
                end
            end
            checks++;
            if (bus_if.rsp_hit !== exp_hit || bus_if.rsp_stamp0 !== exp_s0 ||
                bus_if.rsp_stamp1 !== exp_s1) begin
                failures++;
                $display("FAIL %s rsp_data %0d: hit=%b s0=%0d s1=%0d required hit=%b s0=%0d s1=%0d",
                         name, d, bus_if.rsp_hit, bus_if.rsp_stamp0, bus_if.rsp_stamp1,
                         exp_hit, exp_s0, exp_s1);
            end
        end

        bus_if.rsp_ready = 1'b1;
        step();
        bus_if.rsp_ready = 1'b0;
        checks++;
        if (bus_if.rsp_valid !== 1'b0 || bus_if.cmd_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL %s back_to_idle: valid=%b ready=%b busy=%b required 0 1 0",
                     name, bus_if.rsp_valid, bus_if.cmd_ready, busy);
        end
    endtask

    task automatic check_idle_reset(input string name);
        checks++;
        if (trigs_out !== 1'b0 || busy !== 1'b0 || bus_if.rsp_valid !== 1'b0 ||
            bus_if.cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s ctrl: trig=%b busy=%b valid=%b ready=%b required 0 0 0 1",
                     name, trigs_out, busy, bus_if.rsp_valid, bus_if.cmd_ready);
        end
        checks++;
        if (bus_if.rsp_hit !== 2'b00 || bus_if.rsp_stamp0 !== STAMP_NONE ||
            bus_if.rsp_stamp1 !== STAMP_NONE) begin
            failures++;
            $display("FAIL %s data: hit=%b s0=%h s1=%h required hit=00 s0=ffff s1=ffff",
                     name, bus_if.rsp_hit, bus_if.rsp_stamp0, bus_if.rsp_stamp1);
        end
    endtask

    task automatic test_reset();
        io_reset = 1'b1;
        repeat (3) step();
        io_reset = 1'b0;
        check_idle_reset("reset");
    endtask

    task automatic test_no_edges();
        clear_waves(1'b0, 1'b0);
        run_shot(4, 100, 0, 1'b0, "no_edges");
    endtask

    task automatic test_two_edges();
        clear_waves(1'b0, 1'b0);
        set_level(0, 20, WLEN, 1'b1);
        set_level(1, 35, WLEN, 1'b1);
        run_shot(2, 200, 1, 1'b0, "two_edges");
    endtask

    task automatic test_pre_high();
        clear_waves(1'b0, 1'b1);
        set_level(1, 10, WLEN, 1'b0);
        set_level(1, 30, WLEN, 1'b1);
        set_level(0, 5, 8, 1'b1);
        set_level(0, 12, WLEN, 1'b1);
        run_shot(3, 50, 0, 1'b0, "pre_high");
    endtask

    task automatic test_back_to_back();
        int n;
        clear_waves(1'b0, 1'b0);
        run_shot(0, 0, 2, 1'b1, "zero_len_hold");
        step();
        bus_if.cmd_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || trigs_out !== 1'b1 || bus_if.cmd_ready !== 1'b0) begin
            failures++;
            $display("FAIL held_cmd_accept: busy=%b trig=%b ready=%b required 1 1 0",
                     busy, trigs_out, bus_if.cmd_ready);
        end
        n = 0;
        while (bus_if.rsp_valid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (n != 2) begin
            failures++;
            $display("FAIL held_cmd_rsp_latency: got %0d cycles required 2", n);
        end
        bus_if.rsp_ready = 1'b1;
        step();
        bus_if.rsp_ready = 1'b0;
        checks++;
        if (bus_if.cmd_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL held_cmd_idle: ready=%b busy=%b required 1 0", bus_if.cmd_ready, busy);
        end
    endtask

    task automatic test_rsp_hold();
        clear_waves(1'b0, 1'b0);
        set_level(0, 2, WLEN, 1'b1);
        run_shot(1, 5, 10, 1'b0, "rsp_hold");
    endtask

    task automatic test_reset_mid();
        int n;
        trigs_in = 2'b00;
        bus_if.cmd_valid = 1'b0;
        repeat (6) step();
        bus_if.cmd_pulse_len = 8'd10;
        bus_if.cmd_timeout   = 16'd50;
        bus_if.cmd_valid     = 1'b1;
        step();
        bus_if.cmd_valid = 1'b0;
        repeat (2) step();
        io_reset = 1'b1;
        step();
        io_reset = 1'b0;
        check_idle_reset("reset_mid_pulse");

        bus_if.cmd_pulse_len = 8'd1;
        bus_if.cmd_timeout   = 16'd20;
        bus_if.cmd_valid     = 1'b1;
        step();
        bus_if.cmd_valid = 1'b0;
        trigs_in = 2'b11;
        n = 0;
        while (bus_if.rsp_valid !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        checks++;
        if (bus_if.rsp_valid !== 1'b1 || bus_if.rsp_hit !== 2'b11) begin
            failures++;
            $display("FAIL reset_mid_rsp_setup: valid=%b hit=%b required valid=1 hit=11",
                     bus_if.rsp_valid, bus_if.rsp_hit);
        end
        io_reset = 1'b1;
        step();
        io_reset = 1'b0;
        trigs_in = 2'b00;
        check_idle_reset("reset_mid_rsp");
    endtask

    task automatic test_random();
        for (int it = 0; it < 12; it++) begin
            gen_wave(25);
            run_shot(int'($urandom_range(0, 20)), int'($urandom_range(0, 250)),
                     int'($urandom_range(0, 3)), 1'b0, $sformatf("random%0d", it));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus_if.cmd_valid     = 1'b0;
        bus_if.cmd_pulse_len = '0;
        bus_if.cmd_timeout   = '0;
        bus_if.rsp_ready     = 1'b0;
        #1;
        test_reset();
        test_no_edges();
        test_two_edges();
        test_pre_high();
        test_back_to_back();
        test_rsp_hold();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
